// File: rtl/uart_packet_tx.sv
// Sends one PKT_LEN-bit packet as back-to-back 8N1 frames, LSB of val_in first,
// then holds the line idle for GAP_CYCLES so the peer's idle timeout closes the packet.
module uart_packet_tx #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DIVISOR    = 6771,
  parameter int PKT_LEN    = 208,
  parameter int GAP_CYCLES = 260_000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               trigger_in,
  input  logic [PKT_LEN-1:0] val_in,
  output logic               data_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int BYTES = PKT_LEN / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = $clog2(DIVISOR);
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

  if (DIVISOR < 2 || PKT_LEN % 8 != 0 || GAP_CYCLES < 1 || CLK_HZ / BAUD_RATE < 2) begin : g_param_check
    $error("uart_packet_tx: invalid parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t             state;
  logic [CW-1:0]      baud_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [2:0]         bit_idx;
  logic [BW-1:0]      byte_idx;
  logic [PKT_LEN-1:0] shift_reg;
  logic               prev;
  logic               baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Outputs are registered alongside the state, so data_out changes on the same
  // edge the state does; the shift register always presents the next bit at [0].
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      data_out  <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      baud_cnt  <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      prev      <= trigger_in;
    end else begin
      prev     <= trigger_in;
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          data_out <= 1'b1;
          busy_out <= 1'b0;
          if (trigger_in && !prev) begin
            shift_reg <= val_in;
            byte_idx  <= '0;
            baud_cnt  <= '0;
            data_out  <= 1'b0;
            busy_out  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            data_out  <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[PKT_LEN-1:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              data_out <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              data_out  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[PKT_LEN-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= byte_idx + 1'b1;
              data_out <= 1'b0;
              state    <= START;
            end else begin
              done_out <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            busy_out <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          data_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: a UART receiver model decodes the line and checks
// each received packet against a queue of packets expected to be accepted.
module tb_uart_packet_tx;

  localparam int DIV     = 4;
  localparam int PLEN    = 16;
  localparam int GAP     = 20;
  localparam int NBYTES  = PLEN / 8;
  localparam int PKT_CYC = NBYTES * 10 * DIV;

  logic            clk        = 1'b0;
  logic            rst_in     = 1'b1;
  logic            trigger_in = 1'b1;
  logic [PLEN-1:0] val_in     = '0;
  logic            data_out;
  logic            busy_out;
  logic            done_out;

  uart_packet_tx #(
    .DIVISOR   (DIV),
    .PKT_LEN   (PLEN),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .trigger_in(trigger_in),
    .val_in    (val_in),
    .data_out  (data_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int check_count = 0;
  int pass_count  = 0;
  int trig_cyc    = 0;

  int   done_count      = 0;
  int   done_cyc        = 0;
  int   busy_fall_cyc   = 0;
  int   busy_rise_count = 0;
  int   busy_len        = 0;
  int   last_busy_len   = 0;
  logic busy_prev;

  logic [PLEN-1:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [PLEN-1:0] value, input bit accept);
    @(posedge clk); #1;
    val_in     = value;
    trigger_in = 1'b1;
    trig_cyc   = cyc;
    if (accept) exp_q.push_back(value);
    @(posedge clk); #1;
    trigger_in = 1'b0;
    val_in     = ~value;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy_out !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (busy_out !== 1'b0) checkOutput("idle_timeout", busy_out, 0);
  endtask

  // Receiver model: samples every cycle, requires each bit to be stable for
  // DIV cycles, and assembles bytes LSB first into a packet.
  initial begin : monitor
    int              rx_cnt;
    int              rx_nbytes;
    int              b;
    bit              rx_active;
    bit              rx_ok;
    logic            bit_val;
    logic [7:0]      rx_byte;
    logic [PLEN-1:0] rx_pkt;
    logic [PLEN-1:0] expv;
    rx_cnt = 0; rx_nbytes = 0; b = 0; rx_active = 0; rx_ok = 1;
    bit_val = 1'b1; rx_byte = '0; rx_pkt = '0; expv = '0;
    forever begin
      @(negedge clk);
      if (done_out === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (busy_out === 1'b1) begin
        if (busy_prev !== 1'b1) busy_rise_count++;
        busy_len++;
      end else if (busy_prev === 1'b1) begin
        busy_fall_cyc = cyc;
        last_busy_len = busy_len;
        busy_len      = 0;
      end
      busy_prev = busy_out;

      if (rst_in === 1'b1) begin
        rx_active = 0;
        rx_nbytes = 0;
      end else if (!rx_active) begin
        if (data_out === 1'b0) begin
          rx_active = 1;
          rx_cnt    = 1;
          rx_ok     = 1;
          bit_val   = 1'b0;
        end
      end else begin
        if (rx_cnt % DIV == 0) bit_val = data_out;
        else if (data_out !== bit_val) rx_ok = 0;
        if (rx_cnt % DIV == DIV - 1) begin
          b = rx_cnt / DIV;
          if (b >= 1 && b <= 8) rx_byte[b-1] = bit_val;
          if (b == 9) begin
            checkOutput("bit_timing", rx_ok, 1);
            checkOutput("stop_bit", bit_val, 1);
            rx_pkt[8*rx_nbytes +: 8] = rx_byte;
            rx_nbytes++;
            rx_active = 0;
            if (rx_nbytes == NBYTES) begin
              rx_nbytes = 0;
              if (exp_q.size() == 0) checkOutput("unexpected_packet", 1, 0);
              else begin
                expv = exp_q.pop_front();
                checkOutput("packet", rx_pkt, expv);
              end
            end
          end
        end
        rx_cnt++;
      end
    end
  end

  initial begin : stimulus
    int t0;
    int d0;

    // Reset with trigger held high through release must not start a frame.
    rst_in = 1'b1; trigger_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset_line", data_out, 1);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_no_frame", busy_rise_count, 0);
    checkOutput("reset_done", done_count, 0);
    trigger_in = 1'b0;
    repeat (2) @(posedge clk);

    // Single packet with exact start, done and busy-fall timing.
    d0 = done_count;
    applyStimulus(16'hA53C, 1);
    t0 = trig_cyc;
    waitUntil(t0 + 1);
    checkOutput("start_line", data_out, 0);
    checkOutput("start_busy", busy_out, 1);
    waitIdle(300);
    checkOutput("done_cycle", done_cyc, t0 + PKT_CYC + 1);
    checkOutput("done_count", done_count - d0, 1);
    checkOutput("busy_fall", busy_fall_cyc, t0 + PKT_CYC + GAP + 1);

    // A second edge mid-packet with new data is ignored.
    d0 = done_count;
    applyStimulus(16'hA53C, 1);
    t0 = trig_cyc;
    waitUntil(t0 + 29);
    applyStimulus(16'h1234, 0);
    waitIdle(300);
    checkOutput("busy_trig_done_cycle", done_cyc, t0 + PKT_CYC + 1);
    checkOutput("busy_trig_done_count", done_count - d0, 1);
    checkOutput("busy_trig_fall", busy_fall_cyc, t0 + PKT_CYC + GAP + 1);

    // Edge during the gap is ignored; edge right after busy falls is accepted.
    d0 = done_count;
    applyStimulus(16'h5A81, 1);
    t0 = trig_cyc;
    waitUntil(t0 + PKT_CYC + 4);
    applyStimulus(16'hFFFF, 0);
    waitIdle(300);
    checkOutput("gap_fall", busy_fall_cyc, t0 + PKT_CYC + GAP + 1);
    applyStimulus(16'h7E18, 1);
    t0 = trig_cyc;
    waitUntil(t0 + 1);
    checkOutput("gap_retrig_line", data_out, 0);
    checkOutput("gap_retrig_busy", busy_out, 1);
    waitIdle(300);
    checkOutput("gap_done_count", done_count - d0, 2);

    // Reset during bit 3 of byte 0 abandons the packet without a done pulse.
    d0 = done_count;
    applyStimulus(16'hC3E7, 1);
    t0 = trig_cyc;
    waitUntil(t0 + 17);
    @(posedge clk); #1;
    rst_in = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_in = 1'b0;
    checkOutput("midreset_line", data_out, 1);
    checkOutput("midreset_busy", busy_out, 0);
    repeat (PKT_CYC + GAP + 10) @(negedge clk);
    #1;
    checkOutput("midreset_no_done", done_count - d0, 0);
    checkOutput("midreset_idle", busy_out, 0);
    applyStimulus(16'hC3E7, 1);
    waitIdle(300);
    checkOutput("midreset_resend_done", done_count - d0, 1);

    // Alternating 0x55/0xAA bytes; busy spans packet plus gap exactly.
    d0 = done_count;
    applyStimulus(16'hAA55, 1);
    waitIdle(300);
    checkOutput("busy_length", last_busy_len, PKT_CYC + GAP);
    checkOutput("alt_done_count", done_count - d0, 1);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("total_done", done_count, 6);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
Serializes one PKT_LEN-bit board/move packet onto a single UART line for the peer board's packet receiver. The packet is sent as back-to-back 8N1 byte frames at BAUD_RATE, followed by an enforced idle gap. The receiver uses a WAIT_TIME line-idle timeout to delimit packets, so the gap must exceed that timeout. The block sits between the game logic (packet source, debounced send button) and pin ja[0], and runs on the 65 MHz system clock.

Parameters:
CLK_HZ, 65_000_000, system clock frequency (documentation only; DIVISOR is precomputed)
BAUD_RATE, 9600, line rate (documentation only)
DIVISOR, 6771, clock cycles per UART bit (CLK_HZ/BAUD_RATE)
PKT_LEN, 208, packet width in bits; must be a multiple of 8 (208 = 26 bytes)
GAP_CYCLES, 260_000, minimum idle-high cycles after the last stop bit (4 ms; exceeds the receiver's 130_000-cycle timeout)

Ports:
clk_in  input  1  system clock, 65 MHz
rst_in  input  1  synchronous, active-high reset
trigger_in  input  1  debounced level; a rising edge requests transmission
val_in  input  PKT_LEN  packet payload; sampled on the accepted trigger edge
data_out  output  1  UART line; idles high
busy_out  output  1  high while a packet or its gap is in progress
done_out  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: data_out=1, busy_out=0, done_out=0, state=IDLE, all counters=0. The edge register is loaded with the current trigger_in, so a level held high through reset does not start a transmission.
- Edge detect: an edge is accepted in cycle N when trigger_in=1 and prev=0. prev is updated every cycle.
- On an accepted edge in IDLE:
  - val_in is latched into a shift register.
  - byte_idx=0; the state moves to START.
  - At N+1: data_out=0 and busy_out=1.
- Edges seen in any state other than IDLE are ignored. No queuing.
- Changes to val_in after latching have no effect on the current packet.
- States:
  - IDLE: data_out=1, busy_out=0.
  - START: data_out=0 for DIVISOR cycles, then go to DATA with bit_idx=0.
  - DATA: data_out = current byte bit[bit_idx], LSB first.
    - Each bit is held exactly DIVISOR cycles.
    - After bit 7, go to STOP.
  - STOP: data_out=1 for DIVISOR cycles.
    - If byte_idx < PKT_LEN/8-1: increment byte_idx and go to START. There is no extra idle between frames.
    - Otherwise: pulse done_out for 1 cycle (first cycle of GAP) and go to GAP.
  - GAP: data_out=1, busy_out=1 for GAP_CYCLES cycles, then go to IDLE. busy_out=0 from the first IDLE cycle.
- Byte order: byte k = val_in[8k+7:8k], with byte 0 sent first. Overall bit order on the wire is val_in[0] first, val_in[PKT_LEN-1] last.
- Frame length: 10*DIVISOR cycles. Packet length: (PKT_LEN/8)*10*DIVISOR cycles, which is 1_760_460 cycles at the defaults.
- Baud counter:
  - Counts 0..DIVISOR-1 and wraps at DIVISOR-1 to advance.
  - Width is $clog2(DIVISOR), with GAP using its own counter of width $clog2(GAP_CYCLES+1).
  - There is no cumulative drift: every bit is exactly DIVISOR cycles.
- Reset mid-operation:
  - The next cycle returns to the reset values; data_out=1 immediately.
  - The partial frame is abandoned and there is no GAP.
  - done_out is not pulsed.
- Reset and trigger in the same cycle: reset wins.

Test Plan:
Simulation uses DIVISOR=4, PKT_LEN=16, GAP_CYCLES=20 unless stated.

1. Reset: hold rst_in 3 cycles with trigger_in=1, then release with trigger held high -> data_out=1, busy_out=0, and no frame ever starts.
2. Single packet: val_in=16'hA53C, rising edge at cycle N.
   - Line goes 0 at N+1.
   - Wire sequence, 4 cycles per bit: 0,0,0,1,1,1,1,0,0,1 then 0,1,0,1,0,0,1,0,1,1 (byte 3C, then byte A5).
   - done_out pulses once at N+81.
   - busy_out falls at N+101.
3. Trigger while busy: second rising edge at N+30 with a different val_in -> ignored. Wire output is identical to scenario 2, and exactly one done_out pulse occurs.
4. Gap enforcement: rising edge during GAP ignored; rising edge one cycle after busy_out falls -> accepted, start bit begins the next cycle.
5. Reset mid-byte: assert rst_in during DATA bit 3 of byte 0 -> data_out=1 and busy_out=0 the next cycle, done_out never pulses, and a subsequent trigger sends the full packet from byte 0.
6. Default params: PKT_LEN=208, DIVISOR=6771, pattern of alternating 0x55/0xAA bytes -> looped back into the receiver model, the received bus equals val_in, busy_out is high for 1_760_460+260_000 cycles, and every bit period measures exactly 6771 cycles.
